mem_port_arbiter: RTL and testbench

Shares the single unified memory port between instruction fetch (IF) and load/store (LS) requesters of the RV32 pipeline. Holds at most one memory transaction in flight. Routes each response back to the requester that issued it. Drops fetch responses killed by a taken-branch flush. Produces per-requester stall outputs that feed pipeline stall control alongside the hazard logic.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates IF and LS requesters onto one memory port, one transaction in flight
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int MAX_STARVE = 4,
  parameter int CNT_W      = $clog2(MAX_STARVE + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            ls_req_i,
  input  logic            ls_we_i,
  input  logic [3:0]      ls_be_i,
  input  logic [XLEN-1:0] ls_addr_i,
  input  logic [XLEN-1:0] ls_wdata_i,
  output logic            ls_gnt_o,
  output logic            ls_rvalid_o,
  output logic [XLEN-1:0] ls_rdata_o,
  input  logic            flush_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            stall_if_o,
  output logic            stall_ls_o
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              discard_q, discard_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic active, rsp_fire, arb_en, if_elig, if_wins, ls_wins, owned, kill;

  always_comb begin
    // Outputs are forced quiet in the reset cycle so nothing stale leaks out.
    active   = ~rst_i;
    rsp_fire = active & (state_q == RSP) & mem_rvalid_i;
    arb_en   = active & ((state_q == IDLE) | rsp_fire);
    if_elig  = if_req_i & ~flush_i;
    if_wins  = arb_en & if_elig & (~ls_req_i | (cnt_q == CNT_W'(MAX_STARVE)));
    ls_wins  = arb_en & ls_req_i & ~if_wins;
    owned    = active & (state_q != IDLE);
    kill     = discard_q | flush_i;

    if_gnt_o    = if_wins;
    ls_gnt_o    = ls_wins;
    if_rvalid_o = rsp_fire & (owner_q == OWN_IF) & ~kill;
    ls_rvalid_o = rsp_fire & (owner_q == OWN_LS);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;

    mem_req_o   = active & (state_q == REQ);
    mem_we_o    = mem_req_o & we_q;
    mem_be_o    = mem_req_o ? be_q : 4'h0;
    mem_addr_o  = mem_req_o ? addr_q : '0;
    mem_wdata_o = mem_req_o ? wdata_q : '0;

    stall_if_o = active & ((if_req_i & ~if_gnt_o) |
                           (owned & (owner_q == OWN_IF) & ~kill & ~if_rvalid_o));
    stall_ls_o = active & ((ls_req_i & ~ls_gnt_o) |
                           (owned & (owner_q == OWN_LS) & ~ls_rvalid_o));

    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    discard_d = discard_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    case (state_q)
      IDLE:    if (if_wins | ls_wins) state_d = REQ;
      REQ:     if (mem_gnt_i) state_d = RSP;
      RSP:     if (mem_rvalid_i) state_d = (if_wins | ls_wins) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase

    if (if_wins) begin
      cnt_d = '0;
    end else if (ls_wins & if_elig) begin
      if (cnt_q != CNT_W'(MAX_STARVE)) cnt_d = cnt_q + CNT_W'(1);
    end else if (~if_req_i) begin
      cnt_d = '0;
    end

    if (rsp_fire) begin
      discard_d = 1'b0;
    end else if (owned & (owner_q == OWN_IF) & flush_i) begin
      discard_d = 1'b1;
    end

    if (if_wins) begin
      owner_d = OWN_IF;
      we_d    = 1'b0;
      be_d    = 4'hF;
      addr_d  = if_addr_i;
      wdata_d = '0;
    end else if (ls_wins) begin
      owner_d = OWN_LS;
      we_d    = ls_we_i;
      be_d    = ls_be_i;
      addr_d  = ls_addr_i;
      wdata_d = ls_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      cnt_q     <= '0;
      discard_q <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 4'h0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - transaction-level model checks for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int XLEN = 32;
  localparam int MAX_STARVE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i, if_req_i, ls_req_i, ls_we_i, flush_i, mem_gnt_i, mem_rvalid_i;
  logic [31:0] if_addr_i, ls_addr_i, ls_wdata_i, mem_rdata_i;
  logic [3:0] ls_be_i;
  logic if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o, mem_req_o, mem_we_o, stall_if_o, stall_ls_o;
  logic [31:0] if_rdata_o, ls_rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0] mem_be_o;

  mem_port_arbiter #(.XLEN(XLEN), .MAX_STARVE(MAX_STARVE)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .stall_if_o(stall_if_o), .stall_ls_o(stall_ls_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Outstanding-transaction record: who owns it, whether memory took it, whether it was killed.
  bit          m_have, m_taken, m_ls, m_killed;
  int          m_lost;
  bit          m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit ifr, input logic [31:0] ia,
                      input bit lr, input bit lwe, input logic [3:0] lbe,
                      input logic [31:0] la, input logic [31:0] lwd,
                      input bit fl, input bit mg, input bit mv, input logic [31:0] md);
    bit rsp, free, e_ig, e_lg, e_ir, e_lr, e_req, dead, e_si, e_sl;
    @(posedge clk);
    #1;
    rst_i = rst; if_req_i = ifr; if_addr_i = ia;
    ls_req_i = lr; ls_we_i = lwe; ls_be_i = lbe; ls_addr_i = la; ls_wdata_i = lwd;
    flush_i = fl; mem_gnt_i = mg; mem_rvalid_i = mv; mem_rdata_i = md;
    #4;
    if (rst) begin
      {e_ig, e_lg, e_ir, e_lr, e_req, e_si, e_sl} = '0;
    end else begin
      rsp  = m_have && m_taken && mv;
      free = !m_have || rsp;
      e_ig = free && ifr && !fl && (!lr || m_lost >= MAX_STARVE);
      e_lg = free && lr && !e_ig;
      dead = m_killed || fl;
      e_ir = rsp && !m_ls && !dead;
      e_lr = rsp && m_ls;
      e_req = m_have && !m_taken;
      e_si = (ifr && !e_ig) || (m_have && !m_ls && !dead && !e_ir);
      e_sl = (lr && !e_lg) || (m_have && m_ls && !e_lr);
    end
    chk("if_gnt", if_gnt_o, e_ig);
    chk("ls_gnt", ls_gnt_o, e_lg);
    chk("if_rvalid", if_rvalid_o, e_ir);
    chk("ls_rvalid", ls_rvalid_o, e_lr);
    chk("if_rdata", if_rdata_o, e_ir ? md : 32'h0);
    chk("ls_rdata", ls_rdata_o, e_lr ? md : 32'h0);
    chk("mem_req", mem_req_o, e_req);
    chk("mem_we", mem_we_o, e_req ? m_we : 1'b0);
    chk("mem_be", mem_be_o, e_req ? m_be : 4'h0);
    chk("mem_addr", mem_addr_o, e_req ? m_addr : 32'h0);
    chk("mem_wdata", mem_wdata_o, e_req ? m_wdata : 32'h0);
    chk("stall_if", stall_if_o, e_si);
    chk("stall_ls", stall_ls_o, e_sl);

    if (rst) begin
      m_have = 0; m_taken = 0; m_killed = 0; m_lost = 0;
    end else begin
      if (e_ig) m_lost = 0;
      else if (e_lg && ifr && !fl) m_lost = (m_lost < MAX_STARVE) ? m_lost + 1 : m_lost;
      else if (!ifr) m_lost = 0;
      if (m_have && !m_ls && fl) m_killed = 1;
      if (m_have && !m_taken && mg) m_taken = 1;
      if (rsp) begin m_have = 0; m_killed = 0; end
      if (e_ig || e_lg) begin
        m_have = 1; m_taken = 0; m_killed = 0; m_ls = e_lg;
        m_we    = e_lg ? lwe : 1'b0;
        m_be    = e_lg ? lbe : 4'hF;
        m_addr  = e_lg ? la : ia;
        m_wdata = e_lg ? lwd : 32'h0;
      end
    end
  endtask

  task automatic idle(input bit rst, input bit mg, input bit mv, input logic [31:0] md);
    step(rst, 0, 0, 0, 0, 0, 0, 0, 0, mg, mv, md);
  endtask

  initial begin
    rst_i = 1; if_req_i = 0; if_addr_i = 0; ls_req_i = 0; ls_we_i = 0; ls_be_i = 0;
    ls_addr_i = 0; ls_wdata_i = 0; flush_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    m_have = 0; m_taken = 0; m_ls = 0; m_killed = 0; m_lost = 0;
    m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;

    idle(1, 0, 0, 0);
    idle(1, 1, 1, 32'h1);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_stall_if", stall_if_o, 0);

    // single fetch
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_if_gnt", if_gnt_o, 1);
    chk("t1_stall0", stall_if_o, 0);
    idle(0, 1, 0, 0);
    chk("t1_mem_req", mem_req_o, 1);
    chk("t1_mem_addr", mem_addr_o, 32'h100);
    chk("t1_mem_be", mem_be_o, 4'hF);
    chk("t1_stall1", stall_if_o, 1);
    idle(0, 0, 1, 32'hDEADBEEF);
    chk("t1_rvalid", if_rvalid_o, 1);
    chk("t1_rdata", if_rdata_o, 32'hDEADBEEF);
    chk("t1_stall2", stall_if_o, 0);

    // contention
    step(0, 1, 32'h1000, 1, 0, 4'hF, 32'h2000, 0, 0, 0, 0, 0);
    chk("t2_ls_first", ls_gnt_o, 1);
    chk("t2_stall_if", stall_if_o, 1);
    step(0, 1, 32'h1000, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA5555);
    chk("t2_if_gnt", if_gnt_o, 1);
    chk("t2_ls_rdata", ls_rdata_o, 32'hAAAA5555);
    chk("t2_if_noleak", if_rdata_o, 0);
    idle(0, 1, 0, 0);
    idle(0, 0, 1, 32'h0BB0_0BB0);
    chk("t2_if_rdata", if_rdata_o, 32'h0BB0_0BB0);
    chk("t2_ls_noleak", ls_rvalid_o, 0);

    // starvation
    idle(1, 0, 0, 0);
    for (int c = 0; c <= 10; c++) begin
      step(0, 1, 32'h400 + c, 1, 0, 4'hF, 32'h800 + c, 0, 0, 1, 1, c);
      chk("t3_if_gnt", if_gnt_o, (c == 8));
      chk("t3_ls_gnt", ls_gnt_o, (c % 2 == 0) && (c != 8));
    end
    for (int c = 0; c < 3; c++) idle(0, 1, 1, 32'h77);

    // flush while waiting for memory
    step(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("t4_stall_drop", stall_if_o, 0);
    idle(0, 1, 0, 0);
    chk("t4_req_held", mem_req_o, 1);
    chk("t4_addr_held", mem_addr_o, 32'h40);
    idle(0, 0, 1, 32'hBAD);
    chk("t4_killed", if_rvalid_o, 0);
    step(0, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 1, 0, 0);
    chk("t4_next_addr", mem_addr_o, 32'h80);
    idle(0, 0, 1, 32'h55);
    chk("t4_next_ok", if_rvalid_o, 1);

    // store
    step(0, 0, 0, 1, 1, 4'b0011, 32'h3004, 32'h1234, 0, 0, 0, 0);
    chk("t5_gnt", ls_gnt_o, 1);
    idle(0, 1, 0, 0);
    chk("t5_we", mem_we_o, 1);
    chk("t5_be", mem_be_o, 4'h3);
    chk("t5_wdata", mem_wdata_o, 32'h1234);
    idle(0, 0, 1, 0);
    chk("t5_ack", ls_rvalid_o, 1);

    // reset in RSP
    step(0, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 1, 0, 0);
    idle(1, 0, 0, 0);
    step(0, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 1, 32'hF00D);
    chk("t6_late_rvalid", if_rvalid_o, 0);
    chk("t6_new_gnt", if_gnt_o, 1);
    idle(0, 1, 0, 0);
    chk("t6_addr", mem_addr_o, 32'h200);
    idle(0, 0, 1, 32'h600D);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0), $urandom,
           ($urandom_range(0, 1) == 1), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
           $urandom, $urandom,
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
